dffnq_scan_ctrl: RTL and testbench

- Sequencer for a serial scan chain of CHAIN_LEN negative-edge DFFs (dffnq-type cells) sharing one clock.
- Converts host word transfers (valid/ready) into chain shift, capture and unload cycles.
- Drives the chain's scan enable, scan-in and clock-enable; samples scan-out.
- Sits between the test/debug host interface and the register chain.

---
 rtl/dffnq_scan_ctrl_pkg.sv | 30 +++
 rtl/dffnq_scan_ctrl_if.sv | 30 +++
 rtl/dffnq_scan_shreg.sv | 40 ++++
 rtl/dffnq_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_dffnq_scan_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dffnq_scan_ctrl_pkg.sv
// Shared types and sizing helpers for the dffnq scan-chain sequencer.
package dffnq_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT          = 2'd0,
    OP_CAPTURE        = 2'd1,
    OP_CAPTURE_UNLOAD = 2'd2,
    OP_RSVD           = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  // Host words needed to cover the whole chain.
  function automatic int unsigned nwords(input int unsigned chain_len, input int unsigned w);
    return (chain_len + w - 1) / w;
  endfunction

  // Bits carried by the final (possibly partial) word.
  function automatic int unsigned last_bits(input int unsigned chain_len, input int unsigned w);
    return chain_len - (nwords(chain_len, w) - 1) * w;
  endfunction

endpackage

// File: rtl/dffnq_scan_ctrl_if.sv
// Host handshake plus chain-side scan signals for dffnq_scan_ctrl.
// master = host/chain environment, slave = controller.
interface dffnq_scan_ctrl_if #(parameter int unsigned W = 8);
  logic         START;
  logic [1:0]   OP;
  logic [W-1:0] WDATA;
  logic         WVALID;
  logic         WREADY;
  logic [W-1:0] RDATA;
  logic         RVALID;
  logic         RREADY;
  logic         SE;
  logic         SI;
  logic         SO;
  logic         CE;
  logic         BUSY;
  logic         DONE;
  logic         ERR;
  logic         PARITY;

  modport master (
    output START, OP, WDATA, WVALID, RREADY, SO,
    input  WREADY, RDATA, RVALID, SE, SI, CE, BUSY, DONE, ERR, PARITY
  );

  modport slave (
    input  START, OP, WDATA, WVALID, RREADY, SO,
    output WREADY, RDATA, RVALID, SE, SI, CE, BUSY, DONE, ERR, PARITY
  );
endinterface

// File: rtl/dffnq_scan_shreg.sv
// W-bit transmit/receive shifter pair with a bit counter for one host word.
module dffnq_scan_shreg #(
  parameter int unsigned W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     shift,
  input  logic [W-1:0]             din,
  input  logic                     so,
  output logic                     tx0,
  output logic [W-1:0]             rx,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0] tx;

  // Load a fresh word, or shift tx out LSB first while capturing SO into rx[cnt].
  always_ff @(posedge clk) begin
    if (rst) begin
      tx  <= '0;
      rx  <= '0;
      cnt <= '0;
    end else if (load) begin
      tx  <= din;
      rx  <= '0;
      cnt <= '0;
    end else if (shift) begin
      tx <= tx >> 1;
      for (int unsigned i = 0; i < W; i++) begin
        if (cnt == CW'(i)) rx[i] <= so;
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign tx0 = tx[0];

endmodule

// File: rtl/dffnq_scan_ctrl.sv
// Scan-chain sequencer: turns host word transfers into shift/capture/unload
// cycles on a chain of CHAIN_LEN negative-edge flops.
// Optional: define DFFNQ_SCAN_CTRL_PARITY_EN to report XOR of unloaded bits.
module dffnq_scan_ctrl
  import dffnq_scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned W         = 8
) (
  input  logic              CLK,
  input  logic              RST,
  dffnq_scan_ctrl_if.slave  bus
);
  localparam int unsigned   NW        = nwords(CHAIN_LEN, W);
  localparam int unsigned   LAST      = last_bits(CHAIN_LEN, W);
  localparam int unsigned   CW        = $clog2(W + 1);
  localparam int unsigned   XW        = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] FULL_M1   = CW'(W - 1);
  localparam logic [CW-1:0] LAST_M1   = CW'(LAST - 1);
  localparam logic [XW-1:0] WIDX_LAST = XW'(NW - 1);
  localparam logic [W-1:0]  ONES      = '1;
  localparam logic [W-1:0]  LAST_MASK = ONES >> (W - LAST);

  state_e        state, state_nx;
  op_e           op_q;
  logic [XW-1:0] widx;
  logic          last_word;
  logic          start_go, rx_take;
  logic          ld, sh;
  logic          wready, rvalid, se, si, ce;
  logic          tx0;
  logic [W-1:0]  rx, rdata;
  logic [CW-1:0] cnt;

  assign last_word = (widx == WIDX_LAST);
  assign start_go  = (state == ST_IDLE) && bus.START;
  assign rx_take   = (state == ST_UNLOAD) && bus.RREADY;
  assign rdata     = last_word ? (rx & LAST_MASK) : rx;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Latch the operation at start and track which word is in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q <= OP_SHIFT;
      widx <= '0;
    end else if (start_go) begin
      op_q <= op_e'(bus.OP);
      widx <= '0;
    end else if (rx_take && !last_word) begin
      widx <= widx + XW'(1);
    end
  end

  // Next-state and chain/handshake controls; stalls leave CE low.
  always_comb begin
    state_nx = state;
    wready   = 1'b0;
    rvalid   = 1'b0;
    se       = 1'b0;
    si       = 1'b0;
    ce       = 1'b0;
    ld       = 1'b0;
    sh       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.START) begin
          case (op_e'(bus.OP))
            OP_SHIFT:                     state_nx = ST_LOAD;
            OP_CAPTURE, OP_CAPTURE_UNLOAD: state_nx = ST_CAPTURE;
            default:                      state_nx = ST_FIN;
          endcase
        end
      end
      ST_CAPTURE: begin
        ce       = 1'b1;
        state_nx = (op_q == OP_CAPTURE) ? ST_FIN : ST_LOAD;
      end
      ST_LOAD: begin
        wready = 1'b1;
        if (bus.WVALID) begin
          ld       = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ce = 1'b1;
        se = 1'b1;
        si = tx0;
        sh = 1'b1;
        if (cnt == (last_word ? LAST_M1 : FULL_M1)) state_nx = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        rvalid = 1'b1;
        if (bus.RREADY) state_nx = last_word ? ST_FIN : ST_LOAD;
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  dffnq_scan_shreg #(.W(W)) u_shreg (
    .clk   (CLK),
    .rst   (RST),
    .load  (ld),
    .shift (sh),
    .din   (bus.WDATA),
    .so    (bus.SO),
    .tx0   (tx0),
    .rx    (rx),
    .cnt   (cnt)
  );

`ifdef DFFNQ_SCAN_CTRL_PARITY_EN
  logic par_q;

  // Running XOR of every unloaded bit, restarted with each operation.
  always_ff @(posedge CLK) begin
    if (RST)          par_q <= 1'b0;
    else if (start_go) par_q <= 1'b0;
    else if (rx_take) par_q <= par_q ^ (^rdata);
  end

  assign bus.PARITY = (state == ST_FIN) && par_q;
`else
  assign bus.PARITY = 1'b0;
`endif

  assign bus.WREADY = wready;
  assign bus.RVALID = rvalid;
  assign bus.RDATA  = rdata;
  assign bus.SE     = se;
  assign bus.SI     = si;
  assign bus.CE     = ce;
  assign bus.BUSY   = (state != ST_IDLE);
  assign bus.DONE   = (state == ST_FIN);
  assign bus.ERR    = (state == ST_FIN) && (op_q == OP_RSVD);

endmodule

// File: tb/tb_dffnq_scan_ctrl.sv
// Self-checking bench for dffnq_scan_ctrl with a behavioural negedge chain
// and a transaction-level reference of the chain contents.
module tb_dffnq_scan_ctrl;
  import dffnq_scan_ctrl_pkg::*;

  localparam int unsigned CL = 12;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = nwords(CL, W);
  localparam int unsigned LB = last_bits(CL, W);

  logic CLK = 1'b0;
  logic RST = 1'b1;

  dffnq_scan_ctrl_if #(.W(W)) bus ();

  dffnq_scan_ctrl #(.CHAIN_LEN(CL), .W(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Chain environment: falling-edge flops, bit 0 nearest the output, with a
  // retiming stage on the tail so SO presents the bit just shifted out.
  logic [CL-1:0] chain;
  logic [CL-1:0] func_d;
  logic          so_q = 1'b0;

  always @(negedge CLK) begin
    if (bus.CE) begin
      if (bus.SE) begin
        so_q  <= chain[0];
        chain <= {bus.SI, chain[CL-1:1]};
      end else begin
        chain <= func_d;
      end
    end
  end

  assign bus.SO = so_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [CL-1:0] chain_ref;
  logic [W-1:0]  txw [NW];

  task automatic check_idle_outputs(input string tag);
    check(tag, {bus.BUSY, bus.WREADY, bus.RVALID, bus.RDATA, bus.SE, bus.SI,
                bus.CE, bus.DONE, bus.ERR, bus.PARITY}, '0);
  endtask

  // mode 0: no stalls; 1: random stalls and START pulses while busy;
  // 2: WVALID low 3 cycles per LOAD, RREADY low 2 cycles per UNLOAD.
  // abort_bit >= 0 asserts RST after that shift bit has been observed.
  task automatic run_op(input logic [1:0] op, input int mode, input int abort_bit);
    logic [CL-1:0] src, nc;
    logic [W-1:0]  exp_rd [NW];
    logic          exp_si [$];
    logic [W-1:0]  prev_rd;
    logic          exp_par, exp_err, done_seen, aborted, hold;
    int            n_exp, exp_caps, widx, ridx, sidx, caps, cyc, lw, rw, nb, k;

    src       = (op == 2'd1 || op == 2'd2) ? func_d : chain_ref;
    exp_caps  = (op == 2'd1 || op == 2'd2) ? 1 : 0;
    exp_err   = (op == 2'd3);
    n_exp     = (op == 2'd0 || op == 2'd2) ? NW : 0;
    exp_par   = 1'b0;
    for (int i = 0; i < NW; i++) begin
      nb = (i == NW - 1) ? LB : W;
      exp_rd[i] = '0;
      for (int b = 0; b < nb; b++) begin
        exp_rd[i][b] = src[i*W + b];
        if (n_exp != 0) exp_si.push_back(txw[i][b]);
      end
    end
`ifdef DFFNQ_SCAN_CTRL_PARITY_EN
    if (n_exp != 0) exp_par = ^src;
`endif
    done_seen = 1'b0; aborted = 1'b0; hold = 1'b0; prev_rd = '0;
    widx = 0; ridx = 0; sidx = 0; caps = 0; lw = 0; rw = 0;

    @(posedge CLK); #1;
    bus.START = 1'b1; bus.OP = op; bus.WVALID = 1'b0; bus.RREADY = 1'b0;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    cyc = 1;
    while (!done_seen && !aborted && cyc < 400) begin
      bus.WDATA = (widx < NW) ? txw[widx] : W'($urandom);
      case (mode)
        0: begin bus.WVALID = 1'b1; bus.RREADY = 1'b1; end
        1: begin
          bus.WVALID = ($urandom_range(0, 2) != 0);
          bus.RREADY = ($urandom_range(0, 2) != 0);
          bus.START  = ($urandom_range(0, 5) == 0);
          bus.OP     = 2'($urandom_range(0, 3));
        end
        default: begin bus.WVALID = (lw >= 3); bus.RREADY = (rw >= 2); end
      endcase
      @(negedge CLK);
      if (bus.CE && bus.SE) begin
        if (sidx < exp_si.size()) check("si", bus.SI, exp_si[sidx]);
        sidx++;
      end
      if (bus.CE && !bus.SE) caps++;
      if (op == 2'd3) check("rsvd_no_scan", {bus.SE, bus.CE}, 0);
      if (bus.WREADY || bus.RVALID) check("ce_stall", bus.CE, 0);
      if (bus.WREADY) begin
        if (bus.WVALID) begin widx++; lw = 0; end
        else lw++;
      end
      if (bus.RVALID) begin
        if (hold) check("rdata_hold", bus.RDATA, prev_rd);
        if (bus.RREADY) begin
          if (ridx < n_exp) check("rdata", bus.RDATA, exp_rd[ridx]);
          ridx++; rw = 0; hold = 1'b0;
        end else begin
          rw++; hold = 1'b1; prev_rd = bus.RDATA;
        end
      end else begin
        hold = 1'b0;
      end
      if (bus.DONE) begin
        done_seen = 1'b1;
        check("err", bus.ERR, exp_err);
        check("parity", bus.PARITY, exp_par);
        if (mode == 0 && op == 2'd0) check("latency", cyc, 2*NW + CL + 1);
        if (op == 2'd3) check("rsvd_latency", cyc, 1);
      end
      if (abort_bit >= 0 && sidx == abort_bit + 1) begin
        RST = 1'b1;
        aborted = 1'b1;
      end
      if (!done_seen && !aborted) begin
        @(posedge CLK); #1;
        cyc++;
      end
    end
    bus.START = 1'b0; bus.WVALID = 1'b0; bus.RREADY = 1'b0;

    if (aborted) begin
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check_idle_outputs("rst_mid_shift");
      k = sidx;
      for (int i = 0; i < CL; i++)
        nc[i] = (i < CL - k) ? src[i + k] : exp_si[i - (CL - k)];
      chain_ref = nc;
      return;
    end

    check("done_seen", done_seen, 1);
    check("word_count", ridx, n_exp);
    check("shift_count", sidx, exp_si.size());
    check("capture_count", caps, exp_caps);
    if (n_exp != 0) begin
      for (int i = 0; i < exp_si.size(); i++) nc[i] = exp_si[i];
      chain_ref = nc;
    end else begin
      chain_ref = src;
    end
    @(posedge CLK);
    @(negedge CLK);
    check("done_once", {bus.DONE, bus.BUSY}, 0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < NW; i++) txw[i] = W'($urandom);
  endtask

  initial begin
    bus.START = 1'b0; bus.OP = 2'd0; bus.WDATA = '0;
    bus.WVALID = 1'b0; bus.RREADY = 1'b0;
    chain     = CL'({$urandom, $urandom});
    chain_ref = chain;
    func_d    = '0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset_state");
    @(posedge CLK); #1;
    RST = 1'b0;

    txw[0] = 8'hA5; txw[1] = 8'h0F;
    run_op(2'd0, 0, -1);

    func_d = 12'hABC;
    run_op(2'd1, 0, -1);
    rand_words();
    run_op(2'd0, 0, -1);

    func_d = CL'($urandom);
    rand_words();
    run_op(2'd2, 2, -1);

    run_op(2'd3, 0, -1);
    run_op(2'd3, 1, -1);

    rand_words();
    run_op(2'd0, 0, 3);
    rand_words();
    run_op(2'd0, 1, -1);

    txw[0] = 8'h07; txw[1] = 8'h01;
    run_op(2'd0, 0, -1);
    txw[0] = 8'h07; txw[1] = 8'h00;
    run_op(2'd0, 0, -1);
    rand_words();
    run_op(2'd0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      func_d = CL'($urandom);
      rand_words();
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
